// File: rtl/icache_ctrl_if.sv
// Fetcher, memory-fetch-port and ROB flush signals seen by the instruction cache.
// The slave modport is the cache's view; master is the surrounding pipeline's view.
interface icache_ctrl_if;
    logic        in_fetcher_ce;
    logic [31:0] in_fetcher_addr;
    logic        out_fetcher_ce;
    logic [31:0] out_fetcher_inst;
    logic        out_mem_ce;
    logic [31:0] out_mem_addr;
    logic        in_mem_ce;
    logic [31:0] in_mem_data;
    logic        in_rob_misbranch;

    modport slave (
        input  in_fetcher_ce,
        input  in_fetcher_addr,
        output out_fetcher_ce,
        output out_fetcher_inst,
        output out_mem_ce,
        output out_mem_addr,
        input  in_mem_ce,
        input  in_mem_data,
        input  in_rob_misbranch
    );

    modport master (
        output in_fetcher_ce,
        output in_fetcher_addr,
        input  out_fetcher_ce,
        input  out_fetcher_inst,
        input  out_mem_ce,
        input  out_mem_addr,
        output in_mem_ce,
        output in_mem_data,
        output in_rob_misbranch
    );
endinterface

// File: rtl/icache_ctrl.sv
// Direct-mapped, one-word-per-line instruction cache: local single-cycle hits,
// single-word refills from the memory fetch port, misses cancelled by ROB misbranch.
module icache_ctrl #(
    parameter int INDEX_BITS = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rdy,
    icache_ctrl_if.slave bus
);
    localparam int TAG_BITS = 30 - INDEX_BITS;
    localparam int LINES    = 1 << INDEX_BITS;

    typedef enum logic {
        IDLE,
        MISS
    } state_e;

    state_e                  state_q, state_d;
    logic [LINES-1:0]        valid_q;
    logic [TAG_BITS-1:0]     tag_arr_q [LINES];
    logic [31:0]             data_arr_q [LINES];

    logic                    fetch_ce_q, fetch_ce_d;
    logic [31:0]             fetch_inst_q, fetch_inst_d;
    logic                    mem_ce_q, mem_ce_d;
    logic [31:0]             mem_addr_q, mem_addr_d;
    logic [INDEX_BITS-1:0]   req_idx_q, req_idx_d;
    logic [TAG_BITS-1:0]     req_tag_q, req_tag_d;

    logic [INDEX_BITS-1:0]   lookup_idx;
    logic [TAG_BITS-1:0]     lookup_tag;
    logic                    hit;
    logic                    fill_en;
    logic [1:0]              unused_addr_lsb;

    assign lookup_idx      = bus.in_fetcher_addr[INDEX_BITS+1:2];
    assign lookup_tag      = bus.in_fetcher_addr[31:INDEX_BITS+2];
    assign unused_addr_lsb = bus.in_fetcher_addr[1:0];
    assign hit             = valid_q[lookup_idx] && (tag_arr_q[lookup_idx] == lookup_tag);

    always_comb begin
        state_d      = state_q;
        fetch_ce_d   = 1'b0;
        fetch_inst_d = fetch_inst_q;
        mem_ce_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        req_idx_d    = req_idx_q;
        req_tag_d    = req_tag_q;
        fill_en      = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A misbranch squashes any request arriving in the same cycle.
                if (!bus.in_rob_misbranch && bus.in_fetcher_ce) begin
                    if (hit) begin
                        fetch_ce_d   = 1'b1;
                        fetch_inst_d = data_arr_q[lookup_idx];
                    end else begin
                        mem_ce_d   = 1'b1;
                        mem_addr_d = bus.in_fetcher_addr;
                        req_idx_d  = lookup_idx;
                        req_tag_d  = lookup_tag;
                        state_d    = MISS;
                    end
                end
            end
            MISS: begin
                // Returned data is valid for its address even when the fetch was squashed.
                if (bus.in_mem_ce) begin
                    fill_en = 1'b1;
                    state_d = IDLE;
                    if (!bus.in_rob_misbranch) begin
                        fetch_ce_d   = 1'b1;
                        fetch_inst_d = bus.in_mem_data;
                    end
                end else if (bus.in_rob_misbranch) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            fetch_ce_q   <= 1'b0;
            fetch_inst_q <= '0;
            mem_ce_q     <= 1'b0;
            mem_addr_q   <= '0;
            req_idx_q    <= '0;
            req_tag_q    <= '0;
        end else if (rdy) begin
            state_q      <= state_d;
            fetch_ce_q   <= fetch_ce_d;
            fetch_inst_q <= fetch_inst_d;
            mem_ce_q     <= mem_ce_d;
            mem_addr_q   <= mem_addr_d;
            req_idx_q    <= req_idx_d;
            req_tag_q    <= req_tag_d;
            if (fill_en) begin
                valid_q[req_idx_q] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && rdy && fill_en) begin
            data_arr_q[req_idx_q] <= bus.in_mem_data;
            tag_arr_q[req_idx_q]  <= req_tag_q;
        end
    end

    assign bus.out_fetcher_ce   = fetch_ce_q;
    assign bus.out_fetcher_inst = fetch_inst_q;
    assign bus.out_mem_ce       = mem_ce_q;
    assign bus.out_mem_addr     = mem_addr_q;
endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl: cold miss, hit, conflict eviction, misbranch
// cancellation, simultaneous fill+misbranch, rdy stall and reset mid-miss.
module tb_icache_ctrl;
    logic clk;
    logic rst;
    logic rdy;
    int   compared;
    int   mismatched;

    icache_ctrl_if bus ();

    icache_ctrl #(.INDEX_BITS(6)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one cycle of inputs, clocks it in, then samples 1 time unit after the edge.
    task automatic applyStimulus(input logic fce, input logic [31:0] faddr,
                                 input logic mce, input logic [31:0] mdata,
                                 input logic misb);
        bus.in_fetcher_ce    = fce;
        bus.in_fetcher_addr  = faddr;
        bus.in_mem_ce        = mce;
        bus.in_mem_data      = mdata;
        bus.in_rob_misbranch = misb;
        @(posedge clk);
        #1;
        bus.in_fetcher_ce    = 1'b0;
        bus.in_mem_ce        = 1'b0;
        bus.in_rob_misbranch = 1'b0;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic checkWord(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Checks the pulse outputs; the data/address words only when their pulse is expected.
    task automatic checkOutput(input string tag, input logic fce, input logic [31:0] inst,
                               input logic mce, input logic [31:0] maddr);
        checkBit({tag, ".fetcher_ce"}, bus.out_fetcher_ce, fce);
        checkBit({tag, ".mem_ce"}, bus.out_mem_ce, mce);
        if (fce) checkWord({tag, ".inst"}, bus.out_fetcher_inst, inst);
        if (mce) checkWord({tag, ".mem_addr"}, bus.out_mem_addr, maddr);
    endtask

    initial begin
        compared             = 0;
        mismatched           = 0;
        rst                  = 1'b1;
        rdy                  = 1'b1;
        bus.in_fetcher_ce    = 1'b0;
        bus.in_fetcher_addr  = 32'h0;
        bus.in_mem_ce        = 1'b0;
        bus.in_mem_data      = 32'h0;
        bus.in_rob_misbranch = 1'b0;
        idleCycle();
        idleCycle();
        checkBit("reset.fetcher_ce", bus.out_fetcher_ce, 1'b0);
        checkBit("reset.mem_ce", bus.out_mem_ce, 1'b0);
        checkWord("reset.inst", bus.out_fetcher_inst, 32'h0);
        checkWord("reset.mem_addr", bus.out_mem_addr, 32'h0);
        rst = 1'b0;
        idleCycle();

        $display("[TB] cold miss on 0x10");
        applyStimulus(1'b1, 32'h10, 1'b0, 32'h0, 1'b0);
        checkOutput("cold.req", 1'b0, 32'h0, 1'b1, 32'h10);
        for (int i = 0; i < 5; i++) begin
            idleCycle();
            checkOutput("cold.wait", 1'b0, 32'h0, 1'b0, 32'h0);
        end
        checkWord("cold.addr_hold", bus.out_mem_addr, 32'h10);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h00A00093, 1'b0);
        checkOutput("cold.resp", 1'b1, 32'h00A00093, 1'b0, 32'h0);
        idleCycle();
        checkOutput("cold.pulse_end", 1'b0, 32'h0, 1'b0, 32'h0);

        $display("[TB] hit on 0x10");
        applyStimulus(1'b1, 32'h10, 1'b0, 32'h0, 1'b0);
        checkOutput("hit", 1'b1, 32'h00A00093, 1'b0, 32'h0);

        $display("[TB] conflict between 0x000 and 0x100");
        applyStimulus(1'b1, 32'h000, 1'b0, 32'h0, 1'b0);
        checkOutput("conf.miss0", 1'b0, 32'h0, 1'b1, 32'h000);
        idleCycle();
        applyStimulus(1'b0, 32'h0, 1'b1, 32'hAAAA0000, 1'b0);
        checkOutput("conf.fill0", 1'b1, 32'hAAAA0000, 1'b0, 32'h0);
        applyStimulus(1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
        checkOutput("conf.miss100", 1'b0, 32'h0, 1'b1, 32'h100);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h11111111, 1'b0);
        checkOutput("conf.fill100", 1'b1, 32'h11111111, 1'b0, 32'h0);
        applyStimulus(1'b1, 32'h000, 1'b0, 32'h0, 1'b0);
        checkOutput("conf.evicted0", 1'b0, 32'h0, 1'b1, 32'h000);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checkOutput("conf.cancel0", 1'b0, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
        checkOutput("conf.hit100", 1'b1, 32'h11111111, 1'b0, 32'h0);

        $display("[TB] misbranch mid-miss on 0x40");
        applyStimulus(1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
        checkOutput("mb.miss40", 1'b0, 32'h0, 1'b1, 32'h40);
        idleCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checkOutput("mb.cancel", 1'b0, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b1, 32'h80, 1'b0, 32'h0, 1'b0);
        checkOutput("mb.miss80", 1'b0, 32'h0, 1'b1, 32'h80);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h80808080, 1'b0);
        checkOutput("mb.fill80", 1'b1, 32'h80808080, 1'b0, 32'h0);
        applyStimulus(1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
        checkOutput("mb.still_miss40", 1'b0, 32'h0, 1'b1, 32'h40);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h40404040, 1'b0);
        checkOutput("mb.fill40", 1'b1, 32'h40404040, 1'b0, 32'h0);

        $display("[TB] fill coinciding with misbranch on 0x20");
        applyStimulus(1'b1, 32'h20, 1'b0, 32'h0, 1'b0);
        checkOutput("fm.miss20", 1'b0, 32'h0, 1'b1, 32'h20);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h22222222, 1'b1);
        checkOutput("fm.squashed", 1'b0, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b1, 32'h20, 1'b0, 32'h0, 1'b0);
        checkOutput("fm.hit20", 1'b1, 32'h22222222, 1'b0, 32'h0);

        $display("[TB] misbranch squashes a same-cycle request in IDLE");
        applyStimulus(1'b1, 32'h10, 1'b0, 32'h0, 1'b1);
        checkOutput("idle_mb.hit_req", 1'b0, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b1, 32'h90, 1'b0, 32'h0, 1'b1);
        checkOutput("idle_mb.miss_req", 1'b0, 32'h0, 1'b0, 32'h0);

        $display("[TB] rdy stall during miss on 0x30");
        applyStimulus(1'b1, 32'h30, 1'b0, 32'h0, 1'b0);
        checkOutput("stall.miss30", 1'b0, 32'h0, 1'b1, 32'h30);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);
            checkOutput("stall.frozen", 1'b0, 32'h0, 1'b1, 32'h30);
        end
        rdy = 1'b1;
        idleCycle();
        checkOutput("stall.resume", 1'b0, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h33333333, 1'b0);
        checkOutput("stall.resp", 1'b1, 32'h33333333, 1'b0, 32'h0);
        applyStimulus(1'b1, 32'h30, 1'b0, 32'h0, 1'b0);
        checkOutput("stall.hit30", 1'b1, 32'h33333333, 1'b0, 32'h0);

        $display("[TB] reset mid-miss on 0x50");
        applyStimulus(1'b1, 32'h50, 1'b0, 32'h0, 1'b0);
        checkOutput("rst.miss50", 1'b0, 32'h0, 1'b1, 32'h50);
        rst = 1'b1;
        idleCycle();
        checkBit("rst.fetcher_ce", bus.out_fetcher_ce, 1'b0);
        checkBit("rst.mem_ce", bus.out_mem_ce, 1'b0);
        checkWord("rst.inst", bus.out_fetcher_inst, 32'h0);
        checkWord("rst.mem_addr", bus.out_mem_addr, 32'h0);
        rst = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h55555555, 1'b0);
        checkOutput("rst.late_resp", 1'b0, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b1, 32'h10, 1'b0, 32'h0, 1'b0);
        checkOutput("rst.refetch10", 1'b0, 32'h0, 1'b1, 32'h10);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h00A00093, 1'b0);
        checkOutput("rst.fill10", 1'b1, 32'h00A00093, 1'b0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
